mnist_frame_sequencer: RTL

//  Frame-level controller between the UART word receiver and the DNN core.
//  - Groups incoming 16-bit pixel words into frames of FRAME_LEN words.
//  - Forwards each frame to the DNN, then blocks new input until the

---
 rtl/mnist_frame_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mnist_frame_sequencer.sv
// rtl/mnist_frame_sequencer.sv - frame grouping, result capture and abort recovery between UART words and the DNN core
//
// Groups incoming pixel words into frames of FRAME_LEN words and forwards them to the DNN.
// After a frame, new input is blocked until the classification arrives.
// A stalled link or a hung DNN is recovered by a one-cycle ABORT that pulses dnn_rst_o.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   rx_data_i/rx_valid_i  word strobe from the UART receiver
//   dnn_data_o/valid_o    pixel word strobe to the DNN, one cycle after rx
//   dnn_rst_o             one-cycle abort pulse to the DNN
//   dnn_out_i/valid_i     classification word strobe from the DNN
//   result_o/valid_o      latched digit and its update pulse
//   busy_o                high whenever not idle
//   frame_count_o         completed frames, wraps
//   drop_count_o          discarded words, saturates at 255
//   err_gap_o             pulse on inter-word gap abort
//   err_timeout_o         pulse on result timeout abort
module mnist_frame_sequencer #(
    parameter int DATA_W         = 16,
    parameter int FRAME_LEN      = 784,
    parameter int GAP_TIMEOUT    = 1_000_000,
    parameter int RESULT_TIMEOUT = 4_000_000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    output logic [DATA_W-1:0] dnn_data_o,
    output logic              dnn_valid_o,
    output logic              dnn_rst_o,
    input  logic [DATA_W-1:0] dnn_out_i,
    input  logic              dnn_out_valid_i,
    output logic [3:0]        result_o,
    output logic              result_valid_o,
    output logic              busy_o,
    output logic [7:0]        frame_count_o,
    output logic [7:0]        drop_count_o,
    output logic              err_gap_o,
    output logic              err_timeout_o
);

    localparam int PIX_W = $clog2(FRAME_LEN + 1);
    localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
    localparam int RES_W = $clog2(RESULT_TIMEOUT + 1);

    // Counter values seen during the final cycle before completion or expiry.
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
    localparam logic [RES_W-1:0] RES_LAST = RES_W'(RESULT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_ABORT
    } state_t;

    state_t             state_q;
    logic [PIX_W-1:0]   pix_q;
    logic [GAP_W-1:0]   gap_q;
    logic [RES_W-1:0]   res_q;
    logic [DATA_W-1:0]  dnn_data_q;
    logic               dnn_valid_q;
    logic               dnn_rst_q;
    logic [3:0]         result_q;
    logic               result_valid_q;
    logic               busy_q;
    logic [7:0]         frame_q;
    logic [7:0]         drop_q;
    logic               err_gap_q;
    logic               err_timeout_q;

    logic [PIX_W-1:0]   pix_d;
    logic [GAP_W-1:0]   gap_d;
    logic [RES_W-1:0]   res_d;
    logic [7:0]         drop_d;

    // Only the low nibble of the classification word carries the digit.
    logic               unused_dnn_hi;
    assign unused_dnn_hi = ^dnn_out_i[DATA_W-1:4];

    always_comb begin
        pix_d  = pix_q + PIX_W'(1);
        gap_d  = gap_q + GAP_W'(1);
        res_d  = res_q + RES_W'(1);
        drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            pix_q          <= '0;
            gap_q          <= '0;
            res_q          <= '0;
            dnn_data_q     <= '0;
            dnn_valid_q    <= 1'b0;
            dnn_rst_q      <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            frame_q        <= '0;
            drop_q         <= '0;
            err_gap_q      <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            dnn_valid_q    <= 1'b0;
            dnn_rst_q      <= 1'b0;
            result_valid_q <= 1'b0;
            err_gap_q      <= 1'b0;
            err_timeout_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_valid_i) begin
                        dnn_data_q  <= rx_data_i;
                        dnn_valid_q <= 1'b1;
                        pix_q       <= PIX_W'(1);
                        gap_q       <= '0;
                        state_q     <= S_LOAD;
                        busy_q      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // A word arriving on the expiry cycle wins over the gap abort.
                    if (rx_valid_i) begin
                        dnn_data_q  <= rx_data_i;
                        dnn_valid_q <= 1'b1;
                        pix_q       <= pix_d;
                        gap_q       <= '0;
                        if (pix_q == LAST_PIX) begin
                            state_q <= S_WAIT;
                            res_q   <= '0;
                        end
                    end else if (gap_q == GAP_LAST) begin
                        state_q   <= S_ABORT;
                        dnn_rst_q <= 1'b1;
                        err_gap_q <= 1'b1;
                        pix_q     <= '0;
                        gap_q     <= '0;
                    end else begin
                        gap_q <= gap_d;
                    end
                end
                S_WAIT: begin
                    if (rx_valid_i) begin
                        drop_q <= drop_d;
                    end
                    // A result arriving on the expiry cycle wins over the timeout.
                    if (dnn_out_valid_i) begin
                        result_q       <= dnn_out_i[3:0];
                        result_valid_q <= 1'b1;
                        frame_q        <= frame_q + 8'd1;
                        state_q        <= S_IDLE;
                        busy_q         <= 1'b0;
                        pix_q          <= '0;
                        res_q          <= '0;
                    end else if (res_q == RES_LAST) begin
                        state_q       <= S_ABORT;
                        dnn_rst_q     <= 1'b1;
                        err_timeout_q <= 1'b1;
                        pix_q         <= '0;
                        res_q         <= '0;
                    end else begin
                        res_q <= res_d;
                    end
                end
                S_ABORT: begin
                    if (rx_valid_i) begin
                        drop_q <= drop_d;
                    end
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dnn_data_o     = dnn_data_q;
    assign dnn_valid_o    = dnn_valid_q;
    assign dnn_rst_o      = dnn_rst_q;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign busy_o         = busy_q;
    assign frame_count_o  = frame_q;
    assign drop_count_o   = drop_q;
    assign err_gap_o      = err_gap_q;
    assign err_timeout_o  = err_timeout_q;

endmodule
